// File: rtl/fifo_host_driver.sv
// Host-side driver for the 6-bit x 16 pin-level FIFO: bit-bangs the FIFO clock and pins per request.
// Optional pin/status self-check is enabled by defining FIFO_HOST_CHECK_EN.
//
// state | meaning
// INIT  | after reset, launches one FIFO reset cycle (no response)
// IDLE  | req_ready=1, waits for a request
// LOW   | FIFO clock low phase, op pins driven
// HIGH  | FIFO clock high phase, FIFO outputs captured on the last cycle
// RESP  | one-cycle response strobe, pins back to idle
module fifo_host_driver #(
  parameter int HALF_PERIOD = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [5:0] req_data,
  output logic       resp_valid,
  output logic [5:0] resp_data,
  output logic       resp_err,
  output logic       resp_empty_n,
  output logic [4:0] count,
  output logic [7:0] fifo_io_in,
  input  logic [7:0] fifo_io_out,
  output logic       mismatch
);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_LOW, S_HIGH, S_RESP} state_t;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PEEK = 2'b10;
  localparam logic [1:0] OP_RST  = 2'b11;
  localparam logic [7:0] IDLE_PINS = 8'b0000_0100;
  localparam logic [3:0] TMR_LOAD  = 4'(HALF_PERIOD - 1);

  state_t     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [5:0] data_q, data_d;
  logic [7:0] pins_q, pins_d;
  logic [7:0] pat;
  logic [3:0] tmr_q;
  logic       init_q;
  logic [5:0] resp_data_q;
  logic       resp_err_q;
  logic       resp_empty_n_q;
  logic [4:0] count_q;
  logic       accept, reject, tmr_tc;

  assign tmr_tc = (tmr_q == 4'd0);
  assign accept = req_valid && (state_q == S_IDLE);
  assign reject = ((req_op == OP_PUSH) && (count_q == 5'd16)) ||
                  ((req_op == OP_POP)  && (count_q == 5'd0));

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_INIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  state_d = S_LOW;
      S_IDLE:  if (req_valid) state_d = reject ? S_RESP : S_LOW;
      S_LOW:   if (tmr_tc) state_d = S_HIGH;
      S_HIGH:  if (tmr_tc) state_d = init_q ? S_IDLE : S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_RESP);
    op_d   = op_q;
    data_d = data_q;
    if (state_q == S_INIT) begin
      op_d   = OP_RST;
      data_d = 6'd0;
    end else if (accept && !reject) begin
      op_d   = req_op;
      data_d = req_data;
    end
    case (op_d)
      OP_PUSH: pat = {data_d, 2'b10};
      OP_POP:  pat = 8'b0000_1100;
      OP_PEEK: pat = {data_d[3:0], 4'b0100};
      default: pat = 8'b0000_0000;
    endcase
    case (state_d)
      S_LOW:   pins_d = pat;
      S_HIGH:  pins_d = pat | 8'h01;
      default: pins_d = IDLE_PINS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q           <= OP_RST;
      data_q         <= 6'd0;
      pins_q         <= IDLE_PINS;
      tmr_q          <= 4'd0;
      init_q         <= 1'b1;
      resp_data_q    <= 6'd0;
      resp_err_q     <= 1'b0;
      resp_empty_n_q <= 1'b0;
      count_q        <= 5'd0;
    end else begin
      op_q   <= op_d;
      data_q <= data_d;
      pins_q <= pins_d;
      if ((state_d == S_LOW || state_d == S_HIGH) && (state_d != state_q))
        tmr_q <= TMR_LOAD;
      else if (!tmr_tc)
        tmr_q <= tmr_q - 4'd1;
      if (accept && reject) begin
        resp_err_q     <= 1'b1;
        resp_data_q    <= 6'd0;
        resp_empty_n_q <= fifo_io_out[1];
      end
      // Closing edge of the FIFO clock high phase: FIFO outputs are settled.
      if (state_q == S_HIGH && tmr_tc) begin
        if (init_q) begin
          init_q  <= 1'b0;
          count_q <= 5'd0;
        end else begin
          resp_err_q     <= 1'b0;
          resp_empty_n_q <= fifo_io_out[1];
          resp_data_q    <= (op_q == OP_POP || op_q == OP_PEEK) ? fifo_io_out[7:2] : 6'd0;
          case (op_q)
            OP_PUSH: count_q <= count_q + 5'd1;
            OP_POP:  count_q <= count_q - 5'd1;
            OP_RST:  count_q <= 5'd0;
            default: count_q <= count_q;
          endcase
        end
      end
    end
  end

`ifdef FIFO_HOST_CHECK_EN
  logic clk_ok_q;
  logic mismatch_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_ok_q   <= 1'b1;
      mismatch_q <= 1'b0;
    end else begin
      if (accept)
        clk_ok_q <= 1'b1;
      else if (state_q == S_HIGH)
        clk_ok_q <= clk_ok_q & (fifo_io_out[0] == ~pins_q[0]);
      if (state_q == S_RESP && ((resp_empty_n_q != (count_q != 5'd0)) || !clk_ok_q))
        mismatch_q <= 1'b1;
    end
  end

  assign mismatch = mismatch_q;
`else
  logic unused_pin0;
  assign unused_pin0 = fifo_io_out[0];
  assign mismatch    = 1'b0;
`endif

  assign resp_data    = resp_data_q;
  assign resp_err     = resp_err_q;
  assign resp_empty_n = resp_empty_n_q;
  assign count        = count_q;
  assign fifo_io_in   = pins_q;

endmodule
